// File: rtl/parallel_to_serial_if.sv
// parallel_to_serial_if
//   Groups the word-side handshake and the serial-side output pair of the
//   parallel-to-serial converter.
//   Signals:
//     parallel_valid  upstream word valid
//     parallel_ready  converter can accept a word this cycle
//     parallel_data   upstream word (width bits), sampled on accept
//     serial_valid    serial_data carries a valid bit
//     serial_data     current serial bit (LSB of the word first)
//   Modports:
//     slave   converter side
//     master  upstream producer / downstream consumer side
interface parallel_to_serial_if #(
    parameter int width = 8
);
    logic             parallel_valid;
    logic             parallel_ready;
    logic [width-1:0] parallel_data;
    logic             serial_valid;
    logic             serial_data;

    modport slave (
        input  parallel_valid,
        input  parallel_data,
        output parallel_ready,
        output serial_valid,
        output serial_data
    );

    modport master (
        output parallel_valid,
        output parallel_data,
        input  parallel_ready,
        input  serial_valid,
        input  serial_data
    );
endinterface

// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Shifts width-bit words out one bit per cycle, LSB first. A one-word
//   holding buffer in front of the shifter lets the next word be accepted
//   while the current one is still shifting, so back-to-back words stream
//   without idle cycles.
//   Ports:
//     clk  clock, all state changes on the rising edge
//     rst  synchronous active-high reset
//     bus  parallel_to_serial_if.slave: parallel_valid/ready/data in,
//          serial_valid/serial_data out
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    parallel_to_serial_if.slave   bus
);
    localparam int CW = $clog2(width + 1);

    logic [width-1:0] sh_q, sh_d;
    logic [width-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;

    logic accept;
    logic load_now;

    // Ready depends only on the holding flag, so the serial outputs never
    // see a combinational path from the parallel inputs.
    assign bus.parallel_ready = !hold_full_q && !rst;
    assign accept             = bus.parallel_valid && bus.parallel_ready;
    // Shifter is empty or showing its final bit: it can take a new word now.
    assign load_now           = (cnt_q <= CW'(1));

    // rst gates the outputs so nothing valid is shown in the reset cycle,
    // before the registers have actually cleared.
    assign bus.serial_valid   = (cnt_q != '0) && !rst;
    assign bus.serial_data    = bus.serial_valid && sh_q[0];

    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (cnt_q != '0) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q - CW'(1);
        end

        // A load replaces the shift for this cycle. The held word has
        // priority; ready is low while it is held, so no accept competes.
        if (load_now && hold_full_q) begin
            sh_d        = hold_q;
            cnt_d       = CW'(width);
            hold_full_d = 1'b0;
        end else if (load_now && accept) begin
            sh_d  = bus.parallel_data;
            cnt_d = CW'(width);
        end else if (!load_now && accept) begin
            hold_d      = bus.parallel_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q        <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
        end
    end
endmodule

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parallel_to_serial_if #(.width(8)) bus8 ();
    parallel_to_serial_if #(.width(1)) bus1 ();

    parallel_to_serial #(.width(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    parallel_to_serial #(.width(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic       sel;     // 0: width=8 instance, 1: width=1 instance
        logic       r;
        logic       vld;
        logic [7:0] d;
        logic       e_rdy;
        logic       e_sv;
        logic       e_sd;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic v(input logic sel, input logic r, input logic vld, input logic [7:0] d,
                     input logic e_rdy, input logic e_sv, input logic e_sd);
        vec_t t;
        t.sel = sel; t.r = r; t.vld = vld; t.d = d;
        t.e_rdy = e_rdy; t.e_sv = e_sv; t.e_sd = e_sd;
        vq.push_back(t);
    endtask

    // Three words with valid held high: a loads the shifter, b goes to hold,
    // c waits under back-pressure until b moves into the shifter.
    task automatic three_words(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        v(0, 0, 1, a, 1, 0, 0);
        v(0, 0, 1, b, 1, 1, a[0]);
        for (int i = 1; i < 8; i++) v(0, 0, 1, c, 0, 1, a[i]);
        v(0, 0, 1, c, 1, 1, b[0]);
        for (int i = 1; i < 8; i++) v(0, 0, 0, 8'h00, 0, 1, b[i]);
        for (int i = 0; i < 8; i++) v(0, 0, 0, 8'h00, 1, 1, c[i]);
        v(0, 0, 0, 8'h00, 1, 0, 0);
    endtask

    logic [7:0] w;
    logic [7:0] exp_q[$];
    logic [7:0] sr;
    logic [7:0] ew;
    int         nb, got, sent;
    logic       acc;

    initial begin
        bus8.parallel_valid = 1'b0; bus8.parallel_data = '0;
        bus1.parallel_valid = 1'b0; bus1.parallel_data = '0;

        // reset state
        v(0, 1, 0, 8'h00, 0, 0, 0);
        v(0, 1, 1, 8'h5A, 0, 0, 0);
        // single word A5
        w = 8'hA5;
        v(0, 0, 1, w, 1, 0, 0);
        for (int i = 0; i < 8; i++) v(0, 0, 0, 8'h00, 1, 1, w[i]);
        v(0, 0, 0, 8'h00, 1, 0, 0);
        // continuous stream
        three_words(8'h01, 8'hFF, 8'h3C);
        // hold full, 77 back-pressured and 34 not overwritten
        three_words(8'h12, 8'h34, 8'h77);
        // reset at bit 3 of F0 with 55 held; EE offered during reset
        w = 8'hF0;
        v(0, 0, 1, w, 1, 0, 0);
        v(0, 0, 1, 8'h55, 1, 1, w[0]);
        v(0, 0, 0, 8'h00, 0, 1, w[1]);
        v(0, 0, 0, 8'h00, 0, 1, w[2]);
        v(0, 1, 1, 8'hEE, 0, 0, 0);
        w = 8'h81;
        v(0, 0, 1, w, 1, 0, 0);
        for (int i = 0; i < 8; i++) v(0, 0, 0, 8'h00, 1, 1, w[i]);
        v(0, 0, 0, 8'h00, 1, 0, 0);
        v(0, 0, 0, 8'h00, 1, 0, 0);
        // width=1: a word every cycle through the direct-load path
        v(1, 0, 1, 8'h01, 1, 0, 0);
        v(1, 0, 1, 8'h00, 1, 1, 1);
        v(1, 0, 1, 8'h01, 1, 1, 0);
        v(1, 0, 0, 8'h00, 1, 1, 1);
        v(1, 0, 0, 8'h00, 1, 0, 0);

        @(posedge clk); #1;
        foreach (vq[k]) begin
            rst = vq[k].r;
            bus8.parallel_valid = !vq[k].sel && vq[k].vld;
            bus8.parallel_data  = vq[k].d;
            bus1.parallel_valid = vq[k].sel && vq[k].vld;
            bus1.parallel_data  = vq[k].d[0];
            @(negedge clk);
            if (vq[k].sel) begin
                chk("w1_ready", k, 32'(bus1.parallel_ready), 32'(vq[k].e_rdy));
                chk("w1_sv",    k, 32'(bus1.serial_valid),   32'(vq[k].e_sv));
                chk("w1_sd",    k, 32'(bus1.serial_data),    32'(vq[k].e_sd));
            end else begin
                chk("ready", k, 32'(bus8.parallel_ready), 32'(vq[k].e_rdy));
                chk("sv",    k, 32'(bus8.serial_valid),   32'(vq[k].e_sv));
                chk("sd",    k, 32'(bus8.serial_data),    32'(vq[k].e_sd));
            end
            @(posedge clk); #1;
        end
        bus8.parallel_valid = 1'b0;
        bus1.parallel_valid = 1'b0;

        // Loopback: 100 random words with random gaps, reassembled by a
        // bench-side deserializer and compared in order.
        nb = 0; got = 0; sent = 0; sr = '0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            @(negedge clk);
            if (bus8.serial_valid) begin
                sr = {bus8.serial_data, sr[7:1]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        chk("loop_extra_word", got, 32'(sr), 32'hFFFF_FFFF);
                    end else begin
                        ew = exp_q.pop_front();
                        chk("loop_word", got, 32'(sr), 32'(ew));
                    end
                    got++;
                end
            end
            acc = bus8.parallel_valid && bus8.parallel_ready;
            if (acc) exp_q.push_back(bus8.parallel_data);
            @(posedge clk); #1;
            if (acc || !bus8.parallel_valid) begin
                if (sent < 100 && $urandom_range(0, 2) != 0) begin
                    bus8.parallel_valid = 1'b1;
                    bus8.parallel_data  = 8'($urandom);
                    sent++;
                end else begin
                    bus8.parallel_valid = 1'b0;
                end
            end
        end
        chk("loop_words_received", 0, 32'(got), 32'd100);
        chk("loop_queue_empty", 0, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Converts `width`-bit parallel words into a one-bit serial stream, LSB first.
- Sits directly upstream of the serial-to-parallel deserializer. Its `serial_valid`/`serial_data` pair drives that block's serial inputs, so a word sent through both blocks comes back bit-exact.
- A one-word holding buffer plus the shift register let the block accept the next word while shifting the current one, so back-to-back words stream with no idle cycles.

Parameters:
- width, 8, bits per parallel word; legal range is width >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- parallel_valid  input  1  upstream word valid.
- parallel_ready  output  1  block can accept a word this cycle.
- parallel_data  input  width  upstream word; sampled only on accept.
- serial_valid  output  1  serial_data carries a valid bit this cycle.
- serial_data  output  1  current serial bit.

Behaviour:
- Interface: clk is the only clock. rst is synchronous and active-high.

State:
- shift register `sh[width-1:0]`.
- remaining-bit counter `cnt`, range 0..width, width $clog2(width+1).
- holding register `hold[width-1:0]` with flag `hold_full`.

Reset:
- While rst is high: cnt=0, hold_full=0, sh=0, hold=0.
- Outputs during reset: serial_valid=0, serial_data=0, parallel_ready=0.
- Cycle after rst deasserts: parallel_ready=1.

Outputs (from registers only; no combinational path from parallel_* to serial_*):
- serial_valid = (cnt != 0).
- serial_data = sh[0] when serial_valid, else 0.
- parallel_ready = !hold_full && !rst.

Handshake:
- accept = parallel_valid && parallel_ready.
- parallel_data must be held stable while parallel_valid=1 and parallel_ready=0.
- The block never drops or duplicates an accepted word.

Per-cycle update (not in reset):
- shift: if cnt != 0, then sh <= sh >> 1 and cnt <= cnt - 1.
- load_now = (cnt <= 1), meaning the shifter is empty or presenting its last bit this cycle.
- If load_now and hold_full: sh <= hold, cnt <= width, hold_full <= 0.
- If load_now and !hold_full and accept: sh <= parallel_data, cnt <= width.
- If !load_now and accept: hold <= parallel_data, hold_full <= 1.
- A load overrides the shift for that cycle.

Latency and throughput:
- A word accepted in cycle N into an idle shifter: bit0 appears in cycle N+1, bit(width-1) in cycle N+width.
- Words accepted at least one cycle before the previous word's last bit stream contiguously: serial_valid stays high across the word boundary.
- Sustained throughput is 1 word per width cycles.
- With a continuous upstream, parallel_ready is high 1 cycle per word once the buffer is full.

Boundary cases:
- Simultaneous last bit and accept, with hold empty: the word loads the shifter directly with no bubble.
- Hold full: parallel_ready=0. Words are back-pressured until the shifter loads from hold.
- width=1: load_now is true whenever cnt<=1, so one word per cycle, all via the direct-load path.
- Reset mid-word: the partial word and the held word are discarded. serial_valid=0 in the cycle rst is high and in the following cycle.
- parallel_valid while rst=1: ignored, not accepted.

Test Plan:
- width=8, rst then a single word 8'hA5 accepted at cycle 0 -> serial_valid high cycles 1..8, serial_data = 1,0,1,0,0,1,0,1, then serial_valid=0 and serial_data=0.
- Continuous parallel_valid with words 8'h01, 8'hFF, 8'h3C -> 24 consecutive cycles of serial_valid=1 with no gap. parallel_ready pattern: 1,1,0...0, then high one cycle per word. Bit stream matches each word LSB first.
- Loopback into the serial-to-parallel deserializer (width=8), 100 random words with random upstream valid gaps -> each deserializer parallel_valid pulse carries the words in order and bit-exact.
- Hold full, parallel_valid held high with 8'h77 for 7 cycles -> parallel_ready=0 and hold not overwritten. 8'h77 is accepted only after the shifter loads from hold, and appears on serial_data intact.
- Assert rst at the 4th bit of 8'hF0 with a word in hold -> serial_valid=0 the next cycle, no remaining bits emitted, hold_full=0. A new word 8'h81 after reset streams as 1,0,0,0,0,0,0,1.
- width=1, parallel_data toggling 1,0,1 with valid high every cycle -> serial_data 1,0,1 in cycles 1..3, serial_valid continuously 1, parallel_ready continuously 1.
